// File: rtl/dp_mem_rd_arbiter.sv
// Two-requester round-robin read arbiter in front of a single byte-wide memory port.
// One memory transaction is in flight at a time: grant, address phase, then data phase.
module dp_mem_rd_arbiter #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic [ADDR_WIDTH-1:0] S0_ARADDR,
  input  logic                  S0_ARVALID,
  output logic                  S0_ARREADY,
  output logic [7:0]            S0_RDATA,
  output logic                  S0_RVALID,
  input  logic                  S0_RREADY,
  input  logic [ADDR_WIDTH-1:0] S1_ARADDR,
  input  logic                  S1_ARVALID,
  output logic                  S1_ARREADY,
  output logic [7:0]            S1_RDATA,
  output logic                  S1_RVALID,
  input  logic                  S1_RREADY,
  output logic [ADDR_WIDTH-1:0] MEM_ARADDR,
  output logic                  MEM_ARVALID,
  input  logic                  MEM_ARREADY,
  input  logic [7:0]            MEM_RDATA,
  input  logic                  MEM_RVALID,
  output logic                  MEM_RREADY,
  output logic                  OWNER,
  output logic                  BUSY
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t state;
  logic   last_grant;
  logic   any_req;
  logic   grant;
  logic   in_addr;
  logic   in_data;

  // On contention the requester that did not win last time gets the grant.
  always_comb begin
    any_req = S0_ARVALID | S1_ARVALID;
    grant   = (S0_ARVALID && S1_ARVALID) ? ~last_grant : S1_ARVALID;
  end

  assign in_addr = (state == ADDR);
  assign in_data = (state == DATA);

  // Handshakes are passed straight through to the owner; the other side sees zeros.
  assign S0_ARREADY = in_addr && !OWNER && MEM_ARREADY;
  assign S1_ARREADY = in_addr &&  OWNER && MEM_ARREADY;
  assign MEM_RREADY = in_data && (OWNER ? S1_RREADY : S0_RREADY);
  assign S0_RVALID  = in_data && !OWNER && MEM_RVALID;
  assign S1_RVALID  = in_data &&  OWNER && MEM_RVALID;
  assign S0_RDATA   = (in_data && !OWNER) ? MEM_RDATA : 8'h00;
  assign S1_RDATA   = (in_data &&  OWNER) ? MEM_RDATA : 8'h00;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state       <= IDLE;
      MEM_ARADDR  <= '0;
      MEM_ARVALID <= 1'b0;
      OWNER       <= 1'b0;
      BUSY        <= 1'b0;
      last_grant  <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            MEM_ARADDR  <= grant ? S1_ARADDR : S0_ARADDR;
            MEM_ARVALID <= 1'b1;
            OWNER       <= grant;
            BUSY        <= 1'b1;
            state       <= ADDR;
          end
        end
        ADDR: begin
          if (MEM_ARREADY) begin
            MEM_ARVALID <= 1'b0;
            state       <= DATA;
          end
        end
        DATA: begin
          if (MEM_RVALID && MEM_RREADY) begin
            last_grant <= OWNER;
            BUSY       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          MEM_ARVALID <= 1'b0;
          BUSY        <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dp_mem_rd_arbiter.sv
// Scoreboard bench for dp_mem_rd_arbiter: requester drivers, a byte memory model
// and a monitor that checks every returned byte against the expected grant order.
module tb_dp_mem_rd_arbiter;

  localparam int AW = 32;

  logic          ACLK;
  logic          ARESETN;
  logic [AW-1:0] S0_ARADDR, S1_ARADDR;
  logic          S0_ARVALID, S1_ARVALID;
  logic          S0_ARREADY, S1_ARREADY;
  logic [7:0]    S0_RDATA, S1_RDATA;
  logic          S0_RVALID, S1_RVALID;
  logic          S0_RREADY, S1_RREADY;
  logic [AW-1:0] MEM_ARADDR;
  logic          MEM_ARVALID, MEM_ARREADY;
  logic [7:0]    MEM_RDATA;
  logic          MEM_RVALID, MEM_RREADY;
  logic          OWNER, BUSY;

  typedef struct {
    logic       id;
    logic [7:0] data;
  } exp_t;

  exp_t          sb[$];
  logic [AW-1:0] q0[$];
  logic [AW-1:0] q1[$];
  int            vector_count = 0;
  int            miss_count   = 0;
  int            ar_stall     = 0;
  bit            pend         = 0;
  logic [AW-1:0] pend_addr    = '0;
  int            ar_wait      = 0;

  dp_mem_rd_arbiter #(.ADDR_WIDTH(AW)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S0_ARADDR(S0_ARADDR), .S0_ARVALID(S0_ARVALID), .S0_ARREADY(S0_ARREADY),
    .S0_RDATA(S0_RDATA), .S0_RVALID(S0_RVALID), .S0_RREADY(S0_RREADY),
    .S1_ARADDR(S1_ARADDR), .S1_ARVALID(S1_ARVALID), .S1_ARREADY(S1_ARREADY),
    .S1_RDATA(S1_RDATA), .S1_RVALID(S1_RVALID), .S1_RREADY(S1_RREADY),
    .MEM_ARADDR(MEM_ARADDR), .MEM_ARVALID(MEM_ARVALID), .MEM_ARREADY(MEM_ARREADY),
    .MEM_RDATA(MEM_RDATA), .MEM_RVALID(MEM_RVALID), .MEM_RREADY(MEM_RREADY),
    .OWNER(OWNER), .BUSY(BUSY)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  function automatic logic [7:0] mem_byte(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5B;
  endfunction

  function automatic logic [63:0] out_vec();
    return 64'({S0_ARREADY, S1_ARREADY, S0_RDATA, S1_RDATA, S0_RVALID, S1_RVALID,
                MEM_ARADDR, MEM_ARVALID, MEM_RREADY, OWNER, BUSY});
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vector_count++;
    if (observed !== expected) begin
      miss_count++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic id, input logic [AW-1:0] addr, input bit expect_rsp);
    exp_t e;
    e.id   = id;
    e.data = mem_byte(addr);
    if (expect_rsp) sb.push_back(e);
    if (id) q1.push_back(addr);
    else    q0.push_back(addr);
  endtask

  task automatic checkRsp(input logic id, input logic [7:0] data);
    exp_t e;
    checkOutput("sb_has_entry", 64'(sb.size() != 0), 64'(1));
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checkOutput("rsp_id", 64'(id), 64'(e.id));
      checkOutput("rsp_data", 64'(data), 64'(e.data));
    end
  endtask

  task automatic waitCycle();
    @(negedge ACLK);
    #4;
  endtask

  task automatic waitIdle(input string tag, input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      waitCycle();
      if (!BUSY && sb.size() == 0 && q0.size() == 0 && q1.size() == 0) done = 1'b1;
    end
    checkOutput({"drain_", tag}, 64'(done), 64'(1));
  endtask

  // Requester 0: presents queued addresses, pops each one on its ARREADY.
  initial begin
    S0_ARVALID = 1'b0;
    S0_ARADDR  = '0;
    forever begin
      @(negedge ACLK);
      if (q0.size() != 0) begin
        S0_ARVALID = 1'b1;
        S0_ARADDR  = q0[0];
      end else begin
        S0_ARVALID = 1'b0;
      end
      #3;
      if (S0_ARVALID && S0_ARREADY) void'(q0.pop_front());
    end
  end

  initial begin
    S1_ARVALID = 1'b0;
    S1_ARADDR  = '0;
    forever begin
      @(negedge ACLK);
      if (q1.size() != 0) begin
        S1_ARVALID = 1'b1;
        S1_ARADDR  = q1[0];
      end else begin
        S1_ARVALID = 1'b0;
      end
      #3;
      if (S1_ARVALID && S1_ARREADY) void'(q1.pop_front());
    end
  end

  // Memory: accepts an address after ar_stall waiting cycles, then offers its byte.
  initial begin
    MEM_ARREADY = 1'b0;
    MEM_RVALID  = 1'b0;
    MEM_RDATA   = 8'h00;
    forever begin
      @(negedge ACLK);
      if (!ARESETN) begin
        MEM_ARREADY = 1'b0;
        MEM_RVALID  = 1'b0;
        MEM_RDATA   = 8'h00;
        pend        = 1'b0;
        ar_wait     = 0;
      end else begin
        MEM_ARREADY = MEM_ARVALID && (ar_wait >= ar_stall);
        MEM_RVALID  = pend;
        MEM_RDATA   = pend ? mem_byte(pend_addr) : 8'h00;
        #3;
        if (MEM_ARVALID && MEM_ARREADY) begin
          pend      = 1'b1;
          pend_addr = MEM_ARADDR;
          ar_wait   = 0;
        end else if (MEM_ARVALID) begin
          ar_wait++;
        end else begin
          ar_wait = 0;
        end
        if (MEM_RVALID && MEM_RREADY) pend = 1'b0;
      end
    end
  end

  // Monitor: protocol invariants every cycle and scoreboard pops on each byte handshake.
  always begin
    @(negedge ACLK);
    #3;
    if (ARESETN) begin
      checkOutput("ar_r_overlap", 64'(MEM_ARVALID & MEM_RREADY), 64'(0));
      if (BUSY)
        checkOutput("other_side_quiet",
                    OWNER ? 64'({S0_ARREADY, S0_RVALID, S0_RDATA}) : 64'({S1_ARREADY, S1_RVALID, S1_RDATA}),
                    64'(0));
      if (S0_ARREADY) checkOutput("owner_at_s0_arready", 64'(OWNER), 64'(0));
      if (S1_ARREADY) checkOutput("owner_at_s1_arready", 64'(OWNER), 64'(1));
      if (S0_RVALID && S0_RREADY) checkRsp(1'b0, S0_RDATA);
      if (S1_RVALID && S1_RREADY) checkRsp(1'b1, S1_RDATA);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int pulses;
    bit seen;
    ARESETN   = 1'b1;
    S0_RREADY = 1'b1;
    S1_RREADY = 1'b1;
    #1 ARESETN = 1'b0;
    #1 checkOutput("reset_outputs", out_vec(), 64'(0));
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
    #4;

    // First contention after reset: S0, S1, S0, S1.
    applyStimulus(1'b0, 32'h10, 1'b1);
    applyStimulus(1'b1, 32'h20, 1'b1);
    applyStimulus(1'b0, 32'h30, 1'b1);
    applyStimulus(1'b1, 32'h40, 1'b1);
    waitCycle();
    waitCycle();
    checkOutput("contention_first_grant", 64'({OWNER, BUSY, MEM_ARVALID, MEM_ARADDR}), 64'({3'b011, 32'h10}));
    waitIdle("contention", 80);

    // Single request with one cycle of grant latency.
    applyStimulus(1'b0, 32'h100, 1'b1);
    waitCycle();
    checkOutput("single_pre_grant", 64'(MEM_ARVALID), 64'(0));
    waitCycle();
    checkOutput("single_grant", 64'({OWNER, MEM_ARVALID, MEM_ARADDR}), 64'({2'b01, 32'h100}));
    waitIdle("single", 20);

    // Memory address back-pressure for five cycles.
    ar_stall = 5;
    applyStimulus(1'b0, 32'h2A4, 1'b1);
    waitCycle();
    waitCycle();
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) waitCycle();
      if (k <= 5) checkOutput("bp_addr_stable", 64'({MEM_ARVALID, MEM_ARADDR}), 64'({1'b1, 32'h2A4}));
      if (k == 5) checkOutput("bp_arready_on_accept", 64'(S0_ARREADY), 64'(1));
      if (S0_ARREADY) pulses++;
    end
    checkOutput("bp_arready_pulses", 64'(pulses), 64'(1));
    ar_stall = 0;
    waitIdle("backpressure", 20);

    // S1 stalls its read data; S0 must wait behind it.
    S1_RREADY = 1'b0;
    applyStimulus(1'b1, 32'h3C8, 1'b1);
    waitCycle();
    waitCycle();
    checkOutput("stall_grant_s1", 64'({OWNER, BUSY}), 64'(2'b11));
    applyStimulus(1'b0, 32'h055, 1'b1);
    for (int k = 0; k < 6; k++) begin
      waitCycle();
      checkOutput("stall_hold", 64'({MEM_RREADY, BUSY, OWNER, S1_RVALID}), 64'(4'b0111));
    end
    @(negedge ACLK);
    S1_RREADY = 1'b1;
    #4;
    waitIdle("stall", 40);

    // Reset while a byte is being offered; that byte is dropped.
    S0_RREADY = 1'b0;
    applyStimulus(1'b0, 32'h777, 1'b0);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      waitCycle();
      if (MEM_RVALID && BUSY) seen = 1'b1;
    end
    checkOutput("rvalid_before_reset", 64'(seen), 64'(1));
    ARESETN = 1'b0;
    #1 checkOutput("reset_mid_data", out_vec(), 64'(0));
    repeat (2) @(negedge ACLK);
    ARESETN   = 1'b1;
    S0_RREADY = 1'b1;
    #4;

    applyStimulus(1'b0, 32'h500, 1'b1);
    applyStimulus(1'b1, 32'h600, 1'b1);
    waitCycle();
    waitCycle();
    checkOutput("post_reset_grant", 64'({OWNER, MEM_ARADDR}), 64'({1'b0, 32'h500}));
    waitIdle("post_reset", 40);

    checkOutput("sb_final_empty", 64'(sb.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vector_count, miss_count);
    $finish;
  end

endmodule

// File: doc/dp_mem_rd_arbiter.md
DP_MEM_RD_ARBITER -- requirements
Module: dp_mem_rd_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, which sets the byte-address width of all address ports.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset. Ports are listed in REQ-003 to REQ-017 as: name, direction, width, meaning.
REQ-003 ACLK  in  1  single clock; all logic on its rising edge.
REQ-004 ARESETN  in  1  asynchronous, active-low reset.
REQ-005 S0_ARADDR, S1_ARADDR  in  ADDR_WIDTH  requester byte read address.
REQ-006 S0_ARVALID, S1_ARVALID  in  1  requester address valid.
REQ-007 S0_ARREADY, S1_ARREADY  out  1  requester address accepted.
REQ-008 S0_RDATA, S1_RDATA  out  8  returned byte.
REQ-009 S0_RVALID, S1_RVALID  out  1  returned byte valid.
REQ-010 S0_RREADY, S1_RREADY  in  1  requester ready for the byte.
REQ-011 MEM_ARADDR  out  ADDR_WIDTH  memory read address.
REQ-012 MEM_ARVALID  out  1  memory address valid.
REQ-013 MEM_ARREADY  in  1  memory address accepted.
REQ-014 MEM_RDATA  in  8  memory read byte.
REQ-015 MEM_RVALID  in  1  memory byte valid.
REQ-016 MEM_RREADY  out  1  arbiter ready for the memory byte.
REQ-017 OWNER  out  1 (current or last granted requester); BUSY  out  1 (high when the FSM is not in IDLE).

Function
REQ-018 The FSM SHALL have three states: IDLE, ADDR and DATA. Only one memory transaction SHALL be outstanding at a time.
REQ-019 Arbitration in IDLE SHALL work as follows:
- If exactly one ARVALID is high, grant that requester.
- If both are high, grant the requester that is not last_grant (round-robin).
- last_grant resets to 1, so S0 wins the first contention.
REQ-020 On a grant, the block SHALL, on the next edge:
- register the granted ARADDR into MEM_ARADDR;
- set MEM_ARVALID=1, OWNER=grant and BUSY=1;
- move to ADDR.
This gives one cycle of latency from ARVALID to MEM_ARVALID.
REQ-021 In ADDR, MEM_ARADDR and MEM_ARVALID SHALL stay stable until MEM_ARREADY is sampled high.
REQ-022 In ADDR, the granted S*_ARREADY SHALL equal MEM_ARREADY combinationally (a one-cycle pulse). On that edge, MEM_ARVALID clears and the FSM moves to DATA.
REQ-023 The non-granted requester's ARREADY, RVALID and RDATA SHALL be held at 0. Its pending ARVALID SHALL remain unserviced and be arbitrated on the next return to IDLE.
REQ-024 In DATA, the block SHALL pass through combinationally:
- MEM_RREADY = granted S*_RREADY;
- granted S*_RVALID = MEM_RVALID;
- granted S*_RDATA = MEM_RDATA.
REQ-025 When MEM_RVALID and MEM_RREADY are both high in DATA, the block SHALL update last_grant to OWNER and return to IDLE on that edge, with BUSY=0 on the next cycle.
REQ-026 A requester that stalls with RREADY low SHALL hold the arbiter in DATA indefinitely; the other requester waits.
REQ-027 The earliest back-to-back grant SHALL be the cycle after DATA completes, giving a minimum of 3 cycles per transaction.
REQ-028 ARVALID deasserting after a grant SHALL NOT abort the transaction, because the address is already latched.
REQ-029 MEM_ARVALID and MEM_RREADY SHALL never be high in the same cycle.

Reset
REQ-030 On ARESETN low, at any time including mid-transaction, the block SHALL immediately:
- set state=IDLE;
- set MEM_ARADDR=0, MEM_ARVALID=0, MEM_RREADY=0;
- set all S*_ARREADY, S*_RVALID and S*_RDATA to 0;
- set OWNER=0, BUSY=0 and last_grant=1.
Any in-flight memory byte SHALL be discarded.

Verification
REQ-031 Single request: S0_ARVALID=1, S0_ARADDR=0x100, MEM_ARREADY=1, MEM_RDATA=0x5A after 2 cycles -> MEM_ARADDR=0x100 one cycle after the request; S0_RDATA=0x5A with S0_RVALID=1; S1 outputs stay 0.
REQ-032 Contention: both ARVALID held high for 4 transactions -> grants alternate S0, S1, S0, S1; OWNER toggles accordingly.
REQ-033 Back-pressure: MEM_ARREADY held low for 5 cycles -> MEM_ARVALID and MEM_ARADDR stay stable; S0_ARREADY pulses exactly once, in the cycle MEM_ARREADY rises.
REQ-034 Requester stall: S1 granted with S1_RREADY=0 for 6 cycles -> MEM_RREADY=0 and BUSY=1 throughout; S0 is not granted until S1 accepts its byte.
REQ-035 Reset mid-DATA: ARESETN pulled low while MEM_RVALID=1 -> all outputs 0 in the same cycle; after release, the first contention grants S0.
